// File: rtl/rv_stream_packer_pkg.sv
// Shared definitions for the lane-to-word stream packer.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   pack_state_e    - packer FSM states (FILL accepts lanes, HOLD stalls input)
//   lane_cnt_width  - width of the lane index counter for a given PACK_FACTOR
// The packed word struct (data, keep, last) depends on module parameters, so it
// is declared next to the localparams of the modules that carry it.
package rv_pack_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   // Index width for lanes 0..pf-1; never narrower than one bit.
   function automatic int unsigned lane_cnt_width(input int unsigned pf);
      return (pf < 2) ? 1 : $clog2(pf);
   endfunction

endpackage

// File: rtl/rv_stream_packer_if.sv
// Ready/valid bundle for the packer: narrow lane stream in, wide word stream out.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready, standard valid-ready transfer on clk rise.
//
// Signals:
//   in_valid/in_ready/in_data/in_last      - lane stream (DATA_WIDTH payload)
//   out_valid/out_ready/out_data/out_keep/out_last - packed word stream
// Modports: slave = packer view, master = producer/consumer (bench) view.
interface rv_stream_packer_if #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned PACK_FACTOR = 4
);
   logic                              in_valid;
   logic                              in_ready;
   logic [DATA_WIDTH-1:0]             in_data;
   logic                              in_last;
   logic                              out_valid;
   logic                              out_ready;
   logic [DATA_WIDTH*PACK_FACTOR-1:0] out_data;
   logic [PACK_FACTOR-1:0]            out_keep;
   logic                              out_last;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/rv_stream_packer_out_reg.sv
// Single-entry output register for packed words.
// Latency: a loaded word is visible on o_word/o_valid the cycle after i_load.
// Backpressure: holds o_word and o_valid while i_ready=0; o_free tells the packer it may load.
//
// Ports:
//   clk, reset         - clock, async active-high reset
//   i_load, i_word     - load request and word from the packer (only when o_free)
//   i_ready            - downstream ready
//   o_valid, o_word    - registered word and its valid
//   o_free             - register empty or draining this cycle
module rv_pack_out_reg #(
   parameter type T_WORD = logic [7:0]
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  i_load,
   input  T_WORD i_word,
   input  logic  i_ready,
   output logic  o_valid,
   output T_WORD o_word,
   output logic  o_free
);
   logic  r_valid;
   T_WORD r_word;

   // A load in the same cycle as a drain replaces the word with no bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_word  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_word  <= i_word;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_free  = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_word  = r_word;
endmodule

// File: rtl/rv_stream_packer.sv
// Packs PACK_FACTOR consecutive DATA_WIDTH lanes into one wide word, with early flush on in_last.
// Latency: the completing lane appears on out_data one cycle after it is accepted.
// Backpressure: if the output register is busy at completion, FSM enters HOLD and drops in_ready.
//
// Ports:
//   clk, reset - clock, async active-high reset
//   bus        - rv_stream_packer_if.slave (lane stream in, word stream out with keep/last)
// Optional: define RV_PACKER_TIMEOUT_FLUSH_EN to flush a partial word after
// FLUSH_TIMEOUT idle cycles (flushed with out_last=0).
module rv_stream_packer
   import rv_pack_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned PACK_FACTOR   = 4,
   parameter int unsigned FLUSH_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   rv_stream_packer_if.slave   bus
);
   localparam int unsigned LCW = lane_cnt_width(PACK_FACTOR);
   localparam int unsigned WW  = DATA_WIDTH * PACK_FACTOR;

   typedef struct packed {
      logic [WW-1:0]          data;
      logic [PACK_FACTOR-1:0] keep;
      logic                   last;
   } word_t;

   pack_state_e      r_state, w_state_nxt;
   logic [LCW-1:0]   r_lane_cnt, w_lane_cnt_nxt;
   word_t            r_acc, w_acc_nxt;
   word_t            w_fill_word;
   word_t            w_load_word;
   word_t            w_out_word;
   logic             w_accept;
   logic             w_complete;
   logic             w_timeout;
   logic             w_load;
   logic             w_free;
   logic             w_out_valid;

   // in_ready is a pure function of state so upstream sees no combinational loop.
   assign bus.in_ready = (r_state == FILL);
   assign w_accept     = bus.in_valid && (r_state == FILL);

   // Accumulator with the current lane merged in. Unused lanes stay zero
   // because the accumulator is cleared whenever a word leaves it.
   always_comb begin
      w_fill_word      = r_acc;
      w_fill_word.last = 1'b0;
      if (w_accept) begin
         w_fill_word.data[int'(r_lane_cnt)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
         w_fill_word.keep[r_lane_cnt] = 1'b1;
         w_fill_word.last             = bus.in_last;
      end
   end

`ifdef RV_PACKER_TIMEOUT_FLUSH_EN
   localparam int unsigned ICW = $clog2(FLUSH_TIMEOUT + 1);
   logic [ICW-1:0] r_idle_cnt;
   logic           w_idle;

   // Counts only while a partial word waits in FILL; the FLUSH_TIMEOUT-th idle
   // cycle completes the word exactly like in_last, minus the last flag.
   assign w_idle    = (r_state == FILL) && (r_lane_cnt != '0) && !w_accept;
   assign w_timeout = w_idle && (r_idle_cnt == ICW'(FLUSH_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= '0;
      end else if (w_idle && !w_timeout) begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end else begin
         r_idle_cnt <= '0;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign w_complete = (w_accept && ((r_lane_cnt == LCW'(PACK_FACTOR - 1)) || bus.in_last))
                       || w_timeout;

   always_comb begin
      w_state_nxt    = r_state;
      w_lane_cnt_nxt = r_lane_cnt;
      w_acc_nxt      = r_acc;
      w_load         = 1'b0;
      w_load_word    = w_fill_word;
      case (r_state)
         FILL: begin
            if (w_complete) begin
               w_lane_cnt_nxt = '0;
               if (w_free) begin
                  w_load    = 1'b1;
                  w_acc_nxt = '0;
               end else begin
                  // Park the finished word (including its last flag) until the
                  // output register frees up.
                  w_acc_nxt   = w_fill_word;
                  w_state_nxt = HOLD;
               end
            end else if (w_accept) begin
               w_acc_nxt      = w_fill_word;
               w_lane_cnt_nxt = r_lane_cnt + 1'b1;
            end
         end
         HOLD: begin
            if (w_free) begin
               w_load      = 1'b1;
               w_load_word = r_acc;
               w_acc_nxt   = '0;
               w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= FILL;
         r_lane_cnt <= '0;
         r_acc      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lane_cnt <= w_lane_cnt_nxt;
         r_acc      <= w_acc_nxt;
      end
   end

   rv_pack_out_reg #(
      .T_WORD (word_t)
   ) u_out_reg (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_word  (w_load_word),
      .i_ready (bus.out_ready),
      .o_valid (w_out_valid),
      .o_word  (w_out_word),
      .o_free  (w_free)
   );

   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_word.data;
   assign bus.out_keep  = w_out_word.keep;
   assign bus.out_last  = w_out_word.last;
endmodule

// File: tb/tb_rv_stream_packer.sv
// Directed bench for rv_stream_packer (DATA_WIDTH=8, PACK_FACTOR=4).
// Stimulus pushes hand-computed words into a queue; a monitor pops on each
// output transfer and also checks that a stalled word stays put.
module tb_rv_stream_packer;
   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } exp_t;

   logic clk;
   logic reset;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   stall_cnt = 0;

   rv_stream_packer_if #(.DATA_WIDTH(8), .PACK_FACTOR(4)) vif();

   rv_stream_packer #(
      .DATA_WIDTH    (8),
      .PACK_FACTOR   (4),
      .FLUSH_TIMEOUT (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_t e;
      e.data = d;
      e.keep = k;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the lane is accepted.
   task automatic send_lane(input logic [7:0] d, input logic l);
      logic rdy;
      int   waits;
      waits = 0;
      rdy   = 1'b0;
      vif.in_valid = 1'b1;
      vif.in_data  = d;
      vif.in_last  = l;
      while (!rdy) begin
         @(negedge clk);
         rdy = vif.in_ready;
         @(posedge clk);
         if (!rdy) begin
            waits++;
            stall_cnt++;
            if (waits > 60) begin
               check("send_lane_timeout", 32'(waits), 32'd0);
               rdy = 1'b1;
            end
         end
      end
      #1;
      vif.in_valid = 1'b0;
      vif.in_last  = 1'b0;
   endtask

   // Scoreboard monitor.
   logic        mon_held = 1'b0;
   logic [31:0] mon_data;
   logic [3:0]  mon_keep;
   logic        mon_last;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_held = 1'b0;
         end else begin
            if (mon_held) begin
               check("hold_valid", 32'(vif.out_valid), 32'd1);
               check("hold_data", vif.out_data, mon_data);
               check("hold_keep", 32'(vif.out_keep), 32'(mon_keep));
               check("hold_last", 32'(vif.out_last), 32'(mon_last));
            end
            if (vif.out_valid && vif.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", vif.out_data, 32'hxxxx_xxxx);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("word_data", vif.out_data, e.data);
                  check("word_keep", 32'(vif.out_keep), 32'(e.keep));
                  check("word_last", 32'(vif.out_last), 32'(e.last));
               end
            end
            mon_held = vif.out_valid && !vif.out_ready;
            mon_data = vif.out_data;
            mon_keep = vif.out_keep;
            mon_last = vif.out_last;
         end
      end
   end

   task automatic stream8();
      for (int i = 0; i < 8; i++) send_lane(8'(8'h21 + i), 1'b0);
   endtask

   initial begin
      int cyc;
      logic saw;
      reset         = 1'b1;
      vif.in_valid  = 1'b0;
      vif.in_data   = '0;
      vif.in_last   = 1'b0;
      vif.out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 32'(vif.out_valid), 32'd0);
      check("rst_out_data", vif.out_data, 32'd0);
      check("rst_out_keep", 32'(vif.out_keep), 32'd0);
      check("rst_out_last", 32'(vif.out_last), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(vif.in_ready), 32'd1);
      @(posedge clk); #1;

      // Full word, latency of one cycle after the last lane
      push(32'h44332211, 4'b1111, 1'b0);
      send_lane(8'h11, 1'b0);
      send_lane(8'h22, 1'b0);
      send_lane(8'h33, 1'b0);
      send_lane(8'h44, 1'b0);
      @(negedge clk);
      check("latency_valid", 32'(vif.out_valid), 32'd1);
      check("latency_data", vif.out_data, 32'h44332211);
      @(posedge clk); #1;

      // Early flush, next lane starts at lane 0
      push(32'h0000BBAA, 4'b0011, 1'b1);
      push(32'hFFEEDDCC, 4'b1111, 1'b0);
      send_lane(8'hAA, 1'b0);
      send_lane(8'hBB, 1'b1);
      send_lane(8'hCC, 1'b0);
      send_lane(8'hDD, 1'b0);
      send_lane(8'hEE, 1'b0);
      send_lane(8'hFF, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // First-lane in_last, and in_last on the final lane
      push(32'h00000099, 4'b0001, 1'b1);
      push(32'h4D4C4B4A, 4'b1111, 1'b1);
      send_lane(8'h99, 1'b1);
      send_lane(8'h4A, 1'b0);
      send_lane(8'h4B, 1'b0);
      send_lane(8'h4C, 1'b0);
      send_lane(8'h4D, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // 12 continuous lanes, no stall expected
      stall_cnt = 0;
      push(32'h04030201, 4'b1111, 1'b0);
      push(32'h08070605, 4'b1111, 1'b0);
      push(32'h0C0B0A09, 4'b1111, 1'b0);
      for (int i = 1; i <= 12; i++) send_lane(8'(i), 1'b0);
      check("stream_no_stall", 32'(stall_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: first word held, second word parks in HOLD
      push(32'h24232221, 4'b1111, 1'b0);
      push(32'h28272625, 4'b1111, 1'b0);
      vif.out_ready = 1'b0;
      fork
         stream8();
      join_none
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("hold_in_ready", 32'(vif.in_ready), 32'd0);
      check("bp_out_valid", 32'(vif.out_valid), 32'd1);
      check("bp_out_data", vif.out_data, 32'h24232221);
      @(posedge clk); #1;
      vif.out_ready = 1'b1;
      wait fork;
      repeat (3) @(posedge clk);
      #1;
      check("bp_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-operation with a held word and a partial word
      vif.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_lane(8'(8'h41 + i), 1'b0);
      send_lane(8'h31, 1'b0);
      send_lane(8'h32, 1'b0);
      reset = 1'b1;
      #1;
      check("midrst_out_valid", 32'(vif.out_valid), 32'd0);
      check("midrst_out_keep", 32'(vif.out_keep), 32'd0);
      check("midrst_out_data", vif.out_data, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 32'(vif.in_ready), 32'd1);
      @(posedge clk); #1;
      vif.out_ready = 1'b1;
      push(32'h58575655, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send_lane(8'(8'h55 + i), 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Idle partial word
`ifdef RV_PACKER_TIMEOUT_FLUSH_EN
      push(32'h00000077, 4'b0001, 1'b0);
      send_lane(8'h77, 1'b0);
      cyc = 0;
      saw = 1'b0;
      while (!saw && cyc < 40) begin
         @(negedge clk);
         cyc++;
         saw = vif.out_valid;
      end
      check("timeout_cycles", 32'(cyc), 32'd17);
      @(posedge clk); #1;
      push(32'h00000088, 4'b0001, 1'b1);
      send_lane(8'h88, 1'b1);
`else
      send_lane(8'h77, 1'b0);
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (vif.out_valid) saw = 1'b1;
      end
      check("no_timeout_flush", 32'(saw), 32'd0);
      @(posedge clk); #1;
      push(32'h00008877, 4'b0011, 1'b1);
      send_lane(8'h88, 1'b1);
`endif

      cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin
         @(posedge clk);
         cyc++;
      end
      repeat (2) @(posedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rv_stream_packer.md
Name: rv_stream_packer

Overview:
- Downstream consumer of the ready/valid half-buffer pipeline.
- Accepts a DATA_WIDTH-wide ready/valid lane stream and packs PACK_FACTOR consecutive lanes into one wide ready/valid word.
- Supports early flush of a partial word on in_last. Per-lane keep mask on output.
- Sits between the byte-wide pipeline output and wide-word consumers (memory/bus side).

Parameters:
- DATA_WIDTH, 8, lane width in bits.
- PACK_FACTOR, 4, lanes per output word (>=2).
- FLUSH_TIMEOUT, 16, idle cycles before timeout flush (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream lane valid.
- in_ready  out  1  packer can accept a lane.
- in_data  in  DATA_WIDTH  lane payload.
- in_last  in  1  lane closes the current word (flush).
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  DATA_WIDTH*PACK_FACTOR  packed word; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep  out  PACK_FACTOR  bit k=1 when lane k holds real data.
- out_last  out  1  word was closed by in_last.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is asserted and after it releases:
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - lane_cnt=0, state=FILL, so in_ready=1 after release.
  - Reset mid-operation discards any partial word and any held word.
- Transfers happen only on clk rising edges: input when in_valid&&in_ready, output when out_valid&&out_ready.
- State FILL:
  - in_ready=1.
  - An accepted lane is written to acc[lane_cnt] and sets keep[lane_cnt].
  - The word completes when lane_cnt==PACK_FACTOR-1 or in_last=1.
  - On completion, if the output register is free (out_valid==0 or out_ready==1 in the same cycle): the word goes to the output register next cycle, lane_cnt=0, acc_keep clears, state stays FILL.
  - On completion with the output register not free: go to HOLD.
  - Otherwise lane_cnt++.
- State HOLD:
  - in_ready=0.
  - When the output register is free, transfer the accumulator, lane_cnt=0, return to FILL.
- in_ready depends only on state, never on in_valid/in_data/in_last.
- Latency: the completing lane appears in out_data one cycle after its acceptance.
- Throughput: one lane per cycle sustained while out_ready=1, with no bubble at word boundaries.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_keep and out_last are held unchanged and out_valid does not drop.
- When the output drains with no new word loaded, out_valid drops to 0. out_data keeps its last value (don't-care).
- Partial words: unused lanes in out_data are 0, and out_keep has contiguous ones from bit 0.
- in_last on lane index PACK_FACTOR-1 gives a full keep with out_last=1.
- in_valid=1 with in_last=1 as the first lane gives keep=...0001.
- Simultaneous output drain and word completion in the same cycle: new word loads, out_valid stays 1 (back-to-back).
- lane_cnt width is $clog2(PACK_FACTOR) and never exceeds PACK_FACTOR-1.

Optional Feature:
- Macro RV_PACKER_TIMEOUT_FLUSH_EN.
- When defined:
  - An idle counter runs in FILL while lane_cnt>0 and no lane is accepted. It resets on any accepted lane and at reset.
  - When it reaches FLUSH_TIMEOUT, the partial word is completed exactly as an in_last completion, but with out_last=0.
  - It follows the same FILL/HOLD rules and the counter clears.
- When not defined: no counter logic, and a partial word waits indefinitely for more lanes or in_last.

Decomposition:
- Package rv_pack_pkg holds:
  - the state enum typedef {FILL, HOLD};
  - a localparam function for the lane-count width;
  - the word struct typedef (data, keep, last) parameterised through module localparams.
- One sub-module, rv_pack_out_reg: the single-entry output register with hold-under-backpressure and a "free" signal back to the packer.

Test Plan (DATA_WIDTH=8, PACK_FACTOR=4):
- Lanes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> out_data=0x44332211, keep=4'b1111, last=0, one cycle after the 0x44 accept.
- Lanes 0xAA, 0xBB (in_last=1) -> out_data=0x0000BBAA, keep=4'b0011, last=1. The next lane 0xCC lands in lane 0 of the next word.
- 12 continuous lanes 0x01..0x0C, out_ready=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09 on consecutive cycles, in_ready never low.
- out_ready=0 for 10 cycles while streaming:
  - first word held stable;
  - the second word fills, then state HOLD with in_ready=0;
  - on out_ready=1 both words drain in order with no loss or duplication.
- Reset asserted after 2 lanes of a word -> out_valid=0 immediately, in_ready=1 after release. The next 4 lanes 0x55..0x58 give 0x58575655.
- With RV_PACKER_TIMEOUT_FLUSH_EN: lane 0x77 then 16 idle cycles -> out_data=0x00000077, keep=4'b0001, last=0. Without the macro -> no output.
